// File: rtl/lineclk_gen.sv
// Line-clock generator: divides clk_p down to a periodic tick, drives a
// one-cycle event pulse and a vectored interrupt while enabled, exposes a
// single Wishbone CSR and lets a debounced push-button toggle the enable.
//
// Vector FSM states
//   state    | meaning
//   VEC_IDLE | no vector cycle in progress, waiting for istb_i with pending
//   VEC_ACK  | iack_o/ivec_o driven, waiting for istb_i to drop
module lineclk_gen #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TICK_HZ    = 50,
    parameter int unsigned DEB_STAGES = 2,
    parameter bit          TIMER_INIT = 1'b1,
    parameter logic [15:0] VECTOR     = 16'o000100
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o,
    input  logic        istb_i,
    output logic        iack_o,
    output logic [15:0] ivec_o,
    output logic        evnt_o,
    input  logic        timer_button,
    output logic        timer_status
);

    localparam int unsigned DIV_N = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

    typedef enum logic {
        VEC_IDLE = 1'b0,
        VEC_ACK  = 1'b1
    } vec_state_t;

    vec_state_t vec_q, vec_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sync_q, sync_d;
    logic [DEB_STAGES-1:0] deb_q, deb_d;
    logic                  arm_q, arm_d;
    logic                  status_q, status_d;
    logic                  ie_q, ie_d;
    logic                  mon_q, mon_d;
    logic                  pend_q, pend_d;
    logic                  evnt_q, evnt_d;
    logic                  ack_q, ack_d;

    logic tick;
    logic btn_toggle;
    logic wb_req;
    logic csr_wr;
    logic vec_take;
    logic unused_wb;

    // Only the low CSR byte lane carries writable bits.
    assign unused_wb = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:1]};

    assign tick = (cnt_q == CNT_LAST);

    // Free-running divider; nothing but reset touches its phase.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Button synchroniser, tick-sampled debounce and re-arm on release.
    always_comb begin
        sync_d = {sync_q[0], timer_button};
        deb_d  = deb_q;
        if (tick) begin
            deb_d = {deb_q[DEB_STAGES-2:0], sync_q[1]};
        end
        btn_toggle = (&deb_q) & arm_q;
        arm_d      = arm_q;
        if (btn_toggle) begin
            arm_d = 1'b0;
        end else if (deb_q == '0) begin
            arm_d = 1'b1;
        end
    end

    // CSR access, enable/IE/MON updates and the event pulse.
    always_comb begin
        wb_req = wb_cyc_i & wb_stb_i & ~ack_q;
        csr_wr = wb_req & wb_we_i & wb_sel_i[0];
        ack_d  = wb_req;

        // A CSR write to the enable bit overrides a same-cycle button toggle.
        status_d = status_q;
        if (btn_toggle) begin
            status_d = ~status_q;
        end
        if (csr_wr) begin
            status_d = wb_dat_i[0];
        end

        ie_d = ie_q;
        if (csr_wr) begin
            ie_d = wb_dat_i[6];
        end

        // Writing 1 to MON leaves it alone; a tick beats a same-cycle clear.
        mon_d = mon_q;
        if (csr_wr && !wb_dat_i[7]) begin
            mon_d = 1'b0;
        end
        if (tick && status_q) begin
            mon_d = 1'b1;
        end

        evnt_d = tick & status_q;
    end

    // Vector handshake next-state and pending latch.
    always_comb begin
        vec_d    = vec_q;
        vec_take = 1'b0;
        unique case (vec_q)
            VEC_IDLE: begin
                if (istb_i && pend_q) begin
                    vec_d    = VEC_ACK;
                    vec_take = 1'b1;
                end
            end
            VEC_ACK: begin
                if (!istb_i) begin
                    vec_d = VEC_IDLE;
                end
            end
            default: vec_d = VEC_IDLE;
        endcase

        // Disabling clears unconditionally; a tick re-arms after a vector ack.
        pend_d = pend_q;
        if (vec_take) begin
            pend_d = 1'b0;
        end
        if (!ie_d || !status_d) begin
            pend_d = 1'b0;
        end else if (tick && status_q && ie_q) begin
            pend_d = 1'b1;
        end
    end

    // Vector FSM state register.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= VEC_IDLE;
        end else begin
            vec_q <= vec_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sync_q   <= '0;
            deb_q    <= '0;
            arm_q    <= 1'b1;
            status_q <= TIMER_INIT;
            ie_q     <= 1'b0;
            mon_q    <= 1'b0;
            pend_q   <= 1'b0;
            evnt_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            deb_q    <= deb_d;
            arm_q    <= arm_d;
            status_q <= status_d;
            ie_q     <= ie_d;
            mon_q    <= mon_d;
            pend_q   <= pend_d;
            evnt_q   <= evnt_d;
            ack_q    <= ack_d;
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = ack_q ? {8'h00, mon_q, ie_q, 5'b00000, status_q} : 16'h0000;
    assign irq_o        = pend_q;
    assign iack_o       = (vec_q == VEC_ACK);
    assign ivec_o       = (vec_q == VEC_ACK) ? VECTOR : 16'h0000;
    assign evnt_o       = evnt_q;
    assign timer_status = status_q;

endmodule

// File: doc/lineclk_gen.md
LINECLK_GEN -- requirements
Module: lineclk_gen

Interface
REQ-001 The block SHALL have parameters: CLK_HZ default 100000000, input clock frequency; TICK_HZ default 50, tick rate; DEB_STAGES default 2, debounce depth (min 2); TIMER_INIT default 1, enable state after reset; VECTOR default 16'o000100, interrupt vector.
REQ-002 The block SHALL have ports: clk_p in 1, sole clock, all logic on posedge; rst_n in 1, asynchronous active-low reset.
REQ-003 wb_cyc_i in 1, wb_stb_i in 1 (pre-decoded CSR select, 177546), wb_we_i in 1, wb_sel_i in 2, wb_dat_i in 16, wb_dat_o out 16, wb_ack_o out 1: Wishbone slave for CSR.
REQ-004 irq_o out 1, vectored request; istb_i in 1, vector strobe; iack_o out 1, vector ack; ivec_o out 16, vector.
REQ-005 evnt_o out 1, one-cycle EVNT pulse; timer_button in 1, asynchronous toggle button; timer_status out 1, enable indicator.

Function
REQ-006 Divider: N = CLK_HZ/TICK_HZ (integer, N >= 4); counter width $clog2(N); internal tick SHALL be high exactly one cycle every N cycles, first tick in the Nth cycle after rst_n release.
REQ-007 Counter SHALL wrap to 0 on terminal count; no other event (CSR write, button) SHALL disturb phase.
REQ-008 evnt_o SHALL equal tick AND timer_status, registered (one cycle after tick, one cycle wide).
REQ-009 timer_button SHALL pass a 2-flop synchroniser, then be shifted into a DEB_STAGES shift register only on tick cycles.
REQ-010 Shift register all ones and armed: timer_status SHALL toggle once and arm SHALL clear; all zeros: arm SHALL set; mixed: no change.
REQ-011 CSR read data SHALL be {8'b0, MON, IE, 5'b0, timer_status}; MON = bit 7, IE = bit 6, enable = bit 0.
REQ-012 Write with wb_sel_i[0]=1: IE <= dat[6]; timer_status <= dat[0]; dat[7]=0 clears MON, dat[7]=1 leaves MON; wb_sel_i[0]=0 writes SHALL change nothing.
REQ-013 MON SHALL set on every tick while timer_status=1.
REQ-014 Simultaneous tick and MON-clearing write: MON SHALL end 1 (tick wins).
REQ-015 Simultaneous button toggle and bit-0 write: written value SHALL win; arm still clears.
REQ-016 wb_ack_o SHALL be registered: high one cycle after wb_cyc_i&wb_stb_i with ack low, then low for one cycle; no two consecutive ack cycles.
REQ-017 wb_dat_o SHALL be valid when wb_ack_o=1; 16'o0 otherwise.
REQ-018 Pending latch SHALL set on tick when timer_status=1 and IE=1; irq_o = pending.
REQ-019 Pending SHALL clear on IE write 0, on timer_status cleared (write or button), or on vector ack.
REQ-020 Vector FSM: IDLE -> (istb_i & pending) -> ACK: iack_o=1, ivec_o=VECTOR, pending cleared; ACK -> (istb_i=0) -> IDLE.
REQ-021 istb_i while not pending SHALL give no iack_o (FSM stays IDLE); ivec_o SHALL be 0 outside ACK.
REQ-022 Tick during ACK SHALL re-set pending after the clear (request not lost).

Reset
REQ-023 rst_n low SHALL immediately force: counter 0, MON 0, IE 0, pending 0, FSM IDLE, wb_ack_o 0, iack_o 0, evnt_o 0, irq_o 0, synchroniser/shift 0, arm 1, timer_status TIMER_INIT.
REQ-024 Reset mid-transaction or mid-ACK SHALL abort; no ack after release without new strobe.

Verification (CLK_HZ=1000, TICK_HZ=100, N=10, DEB_STAGES=2)
REQ-025 Release reset, idle -> evnt_o pulses at cycles 11, 21, 31; CSR read after first tick = 16'o000201.
REQ-026 Write 16'o000101, await tick -> irq_o=1; istb_i high -> iack_o=1, ivec_o=16'o000100 next cycle, irq_o=0; istb_i low -> iack_o=0.
REQ-027 Write 16'o000001 on tick cycle -> read = 16'o000201 (MON kept).
REQ-028 Hold button 3 ticks -> timer_status 1->0 exactly once, evnt_o stops; release 2 ticks, press 3 ticks -> back to 1.
REQ-029 Write 16'o000100 (enable 0) -> MON frozen, no irq_o/evnt_o over 50 cycles, tick phase unchanged after re-enable.
REQ-030 rst_n low during ACK or wb_ack_o -> all outputs 0 asynchronously, timer_status=TIMER_INIT.
